alu_ctrl_mc: RTL and testbench

//  Combined ALU-control decoder and multi-cycle ALU for the multiple-cycle datapath.

---
 rtl/alu_ctrl_mc_pkg.sv | 37 +++
 rtl/alu_dec.sv | 39 +++
 rtl/alu_ctrl_mc.sv | 192 +++++++++++++++++++
 tb/tb_alu_ctrl_mc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_mc_pkg.sv
// Shared definitions for the multi-cycle ALU block.
//  - ALU control codes produced by the decoder and consumed by the datapath
//  - funct codes that select the multiplier
//  - FSM state encoding
//  - is_mul(): true for the two multiply control codes
package alu_ctrl_mc_pkg;

    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOr    = 4'b0001;
    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluSlt   = 4'b0111;
    localparam logic [3:0] AluMult  = 4'b1000;
    localparam logic [3:0] AluMultu = 4'b1001;

    localparam logic [5:0] FunctMult  = 6'h18;
    localparam logic [5:0] FunctMultu = 6'h19;

    // Low nibble of funct for the plain R-type operations
    localparam logic [3:0] FunctLoAdd = 4'd0;
    localparam logic [3:0] FunctLoSub = 4'd2;
    localparam logic [3:0] FunctLoAnd = 4'd4;
    localparam logic [3:0] FunctLoOr  = 4'd5;
    localparam logic [3:0] FunctLoSlt = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StFix,
        StDone
    } state_e;

    function automatic logic is_mul(input logic [3:0] code);
        return (code == AluMult) || (code == AluMultu);
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU-control decoder.
// Ports:
//  aluOp   in  2        00 add, x1 sub, 10 use funct
//  funct   in  FUNCT_W  R-type function field
//  aluCtr  out 4        decoded ALU control code
module alu_dec
    import alu_ctrl_mc_pkg::*;
#(
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned MUL_EN  = 1
) (
    input  logic [1:0]         aluOp,
    input  logic [FUNCT_W-1:0] funct,
    output logic [3:0]         aluCtr
);

    always_comb begin
        aluCtr = AluAnd;
        if (aluOp == 2'b00) begin
            aluCtr = AluAdd;
        end else if (aluOp[0]) begin
            aluCtr = AluSub;
        end else if ((MUL_EN != 0) && (funct == FUNCT_W'(FunctMult))) begin
            aluCtr = AluMult;
        end else if ((MUL_EN != 0) && (funct == FUNCT_W'(FunctMultu))) begin
            aluCtr = AluMultu;
        end else begin
            case (funct[3:0])
                FunctLoAdd: aluCtr = AluAdd;
                FunctLoSub: aluCtr = AluSub;
                FunctLoAnd: aluCtr = AluAnd;
                FunctLoOr:  aluCtr = AluOr;
                FunctLoSlt: aluCtr = AluSlt;
                default:    aluCtr = AluAnd;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU-control decoder plus multi-cycle ALU with a shift-add multiplier.
// Single-cycle ops finish one cycle after accept; MULTU after WIDTH+1 cycles,
// MULT after WIDTH+2 (extra cycle to apply the sign to the product).
// Ports:
//  clk, reset        rising-edge clock, synchronous active-high reset
//  start             op request, sampled only in IDLE
//  aluOp, funct      operation select
//  a, b              operands, sampled at accept only
//  aluCtr            control code of the accepted op
//  result, zero      registered result and result==0
//  hi, lo            product words, updated when a multiply completes
//  busy, done        multiply in progress / one-cycle completion pulse
module alu_ctrl_mc
    import alu_ctrl_mc_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned MUL_EN  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         aluOp,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [3:0]         aluCtr,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CntW  = $clog2(WIDTH);
    localparam int unsigned ProdW = 2 * WIDTH;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [3:0]       aluctr_q, aluctr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [3:0]       dec_ctr;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH-1:0] mul_mplr_nx;
    logic [ProdW-1:0] prod_fix;
    logic             op_signed;

    alu_dec #(
        .FUNCT_W (FUNCT_W),
        .MUL_EN  (MUL_EN)
    ) u_alu_dec (
        .aluOp  (aluOp),
        .funct  (funct),
        .aluCtr (dec_ctr)
    );

    // Single-cycle datapath on the live operands; only used at accept.
    always_comb begin
        alu_res = a & b;
        case (dec_ctr)
            AluAdd:  alu_res = a + b;
            AluSub:  alu_res = a - b;
            AluOr:   alu_res = a | b;
            AluSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = a & b;
        endcase
    end

    // One shift-add step: conditional add into a WIDTH+1 accumulator, then
    // shift the {acc, mplr} pair right so the carry lands in acc's MSB.
    always_comb begin
        mul_sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        mul_acc_nx  = mul_sum[WIDTH:1];
        mul_mplr_nx = {mul_sum[0], mplr_q[WIDTH-1:1]};
        prod_fix    = neg_q ? (~{acc_q, mplr_q} + ProdW'(1)) : {acc_q, mplr_q};
    end

    assign op_signed = (dec_ctr == AluMult);

    always_comb begin
        state_d  = state_q;
        aluctr_d = aluctr_q;
        result_d = result_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    aluctr_d = dec_ctr;
                    if (is_mul(dec_ctr)) begin
                        // Signed multiply runs on magnitudes; sign is reapplied in FIX.
                        mcand_d = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
                        mplr_d  = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
                        neg_d   = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StMul;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                acc_d  = mul_acc_nx;
                mplr_d = mul_mplr_nx;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    if (aluctr_q == AluMultu) begin
                        hi_d     = mul_acc_nx;
                        lo_d     = mul_mplr_nx;
                        result_d = mul_mplr_nx;
                        zero_d   = (mul_mplr_nx == '0);
                        state_d  = StDone;
                    end else begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                hi_d     = prod_fix[ProdW-1:WIDTH];
                lo_d     = prod_fix[WIDTH-1:0];
                result_d = prod_fix[WIDTH-1:0];
                zero_d   = (prod_fix[WIDTH-1:0] == '0);
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            aluctr_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            aluctr_q <= aluctr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign aluCtr = aluctr_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = (state_q == StMul) || (state_q == StFix);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_alu_ctrl_mc.sv
module tb_alu_ctrl_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   aluOp;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic [3:0]   aluCtr;
    logic [W-1:0] result, hi, lo;
    logic         zero, busy, done;

    alu_ctrl_mc #(
        .WIDTH   (W),
        .FUNCT_W (6),
        .MUL_EN  (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .aluOp  (aluOp),
        .funct  (funct),
        .a      (a),
        .b      (b),
        .aluCtr (aluCtr),
        .result (result),
        .zero   (zero),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctr;
        logic [31:0] res;
        logic        z;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          bsy;
    } vec_t;

    vec_t tv[18];
    logic [31:0] m_hi, m_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: decode priority and arithmetic straight from the op definitions.
    function automatic logic [3:0] m_ctr(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'b0010;
        if (op[0]) return 4'b0110;
        if (fn == 6'h18) return 4'b1000;
        if (fn == 6'h19) return 4'b1001;
        case (fn[3:0])
            4'd0:    return 4'b0010;
            4'd2:    return 4'b0110;
            4'd5:    return 4'b0001;
            4'd10:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic vec_t m_expect(input logic [1:0] op, input logic [5:0] fn,
                                      input logic [31:0] av, input logic [31:0] bv,
                                      input logic [31:0] hprev, input logic [31:0] lprev);
        vec_t v;
        longint          ps;
        longint unsigned pu;
        v.op = op; v.fn = fn; v.a = av; v.b = bv;
        v.ctr = m_ctr(op, fn);
        v.hi = hprev; v.lo = lprev; v.lat = 1; v.bsy = 0;
        case (v.ctr)
            4'b0010: v.res = av + bv;
            4'b0110: v.res = av - bv;
            4'b0001: v.res = av | bv;
            4'b0111: v.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            4'b1000: begin
                ps = longint'($signed(av)) * longint'($signed(bv));
                v.hi = ps[63:32]; v.lo = ps[31:0]; v.res = ps[31:0];
                v.lat = W + 2; v.bsy = W + 1;
            end
            4'b1001: begin
                pu = {32'd0, av} * {32'd0, bv};
                v.hi = pu[63:32]; v.lo = pu[31:0]; v.res = pu[31:0];
                v.lat = W + 1; v.bsy = W;
            end
            default: v.res = av & bv;
        endcase
        v.z = (v.res == 32'd0);
        return v;
    endfunction

    // Called at #1 after a rising edge with the DUT idle; returns likewise.
    task automatic run_and_check(input string tag, input vec_t v);
        int          lat = 0;
        int          bcnt = 0;
        logic [3:0]  c = '0;
        logic [31:0] r = '0, h = '0, l = '0;
        logic        z = 1'b0, bd = 1'b0;
        aluOp = v.op; funct = v.fn; a = v.a; b = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operand changes after accept must not matter.
        aluOp = 2'($urandom); funct = 6'($urandom); a = $urandom; b = $urandom;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k; c = aluCtr; r = result; z = zero; h = hi; l = lo; bd = busy;
                break;
            end
            if (busy) bcnt++;
        end
        check({tag, " latency"}, 64'(lat), 64'(v.lat));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(v.bsy));
        check({tag, " busy_at_done"}, 64'(bd), 64'd0);
        check({tag, " aluCtr"}, 64'(c), 64'(v.ctr));
        check({tag, " result"}, 64'(r), 64'(v.res));
        check({tag, " zero"}, 64'(z), 64'(v.z));
        check({tag, " hi"}, 64'(h), 64'(v.hi));
        check({tag, " lo"}, 64'(l), 64'(v.lo));
        if (lat == 0) begin
            reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t v;
        int   d0, n;
        logic [5:0] fl[7];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h19};

        tv[0]  = '{2'b00, 6'h00, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 32'h0, 32'h0, 1, 0};
        tv[1]  = '{2'b10, 6'h2A, 32'hFFFFFFFD, 32'd2, 4'b0111, 32'd1, 1'b0, 32'h0, 32'h0, 1, 0};
        tv[2]  = '{2'b10, 6'h2A, 32'd2, 32'hFFFFFFFD, 4'b0111, 32'd0, 1'b1, 32'h0, 32'h0, 1, 0};
        tv[3]  = '{2'b01, 6'h00, 32'h1234, 32'h1234, 4'b0110, 32'd0, 1'b1, 32'h0, 32'h0, 1, 0};
        tv[4]  = '{2'b10, 6'h27, 32'hF0, 32'h3C, 4'b0000, 32'h30, 1'b0, 32'h0, 32'h0, 1, 0};
        tv[5]  = '{2'b11, 6'h20, 32'h10, 32'h3, 4'b0110, 32'hD, 1'b0, 32'h0, 32'h0, 1, 0};
        tv[6]  = '{2'b10, 6'h20, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 32'h0, 32'h0, 1, 0};
        tv[7]  = '{2'b10, 6'h25, 32'hF0, 32'h0F, 4'b0001, 32'hFF, 1'b0, 32'h0, 32'h0, 1, 0};
        tv[8]  = '{2'b10, 6'h22, 32'd0, 32'd1, 4'b0110, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1, 0};
        tv[9]  = '{2'b10, 6'h24, 32'hFF00FF00, 32'h0F0F0F0F, 4'b0000, 32'h0F000F00, 1'b0,
                   32'h0, 32'h0, 1, 0};
        tv[10] = '{2'b10, 6'h19, 32'hFFFFFFFF, 32'd2, 4'b1001, 32'hFFFFFFFE, 1'b0,
                   32'h1, 32'hFFFFFFFE, 33, 32};
        tv[11] = '{2'b10, 6'h18, 32'hFFFFFFFD, 32'd4, 4'b1000, 32'hFFFFFFF4, 1'b0,
                   32'hFFFFFFFF, 32'hFFFFFFF4, 34, 33};
        tv[12] = '{2'b10, 6'h18, 32'h80000000, 32'h80000000, 4'b1000, 32'h0, 1'b1,
                   32'h40000000, 32'h0, 34, 33};
        tv[13] = '{2'b10, 6'h18, 32'h0, 32'hFFFFFFF9, 4'b1000, 32'h0, 1'b1, 32'h0, 32'h0, 34, 33};
        tv[14] = '{2'b10, 6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 32'h1, 1'b0,
                   32'h0, 32'h1, 34, 33};
        tv[15] = '{2'b10, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 4'b0111, 32'd1, 1'b0,
                   32'h0, 32'h1, 1, 0};
        tv[16] = '{2'b00, 6'h18, 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0, 32'h0, 32'h1, 1, 0};
        tv[17] = '{2'b01, 6'h19, 32'd9, 32'd4, 4'b0110, 32'd5, 1'b0, 32'h0, 32'h1, 1, 0};

        // Reset held for two cycles: every output cleared.
        reset = 1'b1; start = 1'b0; aluOp = 2'b00; funct = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset aluCtr", 64'(aluCtr), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset zero", 64'(zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 18; i++) run_and_check($sformatf("vec%0d", i), tv[i]);

        // Randomised ops against the reference model.
        m_hi = 32'h0; m_lo = 32'h1;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [5:0]  fn;
            logic [31:0] av, bv;
            op = ($urandom_range(0, 2) != 0) ? 2'b10 : 2'($urandom);
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fl[$urandom_range(0, 6)];
            av = $urandom; bv = $urandom;
            case ($urandom_range(0, 5))
                0: av = 32'h0;
                1: bv = 32'h80000000;
                2: av = 32'hFFFFFFFF;
                default: ;
            endcase
            v = m_expect(op, fn, av, bv, m_hi, m_lo);
            run_and_check($sformatf("rand%0d", i), v);
            m_hi = v.hi; m_lo = v.lo;
        end

        // start held high: re-triggers on every IDLE cycle, ignored in DONE.
        aluOp = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk);
        n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (done) n++;
            if (k == 5) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        check("retrigger done_pulses", 64'(n), 64'd3);
        check("retrigger result", 64'(result), 64'd2);
        @(posedge clk); #1;

        // Leave non-zero hi/lo, then abort a multiply with reset.
        run_and_check("pre_abort multu", tv[10]);
        aluOp = 2'b10; funct = 6'h18; a = 32'hFFFFFFFD; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (4) begin @(posedge clk); #1; end
        aluOp = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_ignore busy", 64'(busy), 64'd1);
        check("busy_ignore aluCtr", 64'(aluCtr), 64'h8);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort no_done", 64'(done_cnt - d0), 64'd0);
        run_and_check("post_abort add", tv[0]);

        // Simultaneous reset and start: reset wins.
        reset = 1'b1; start = 1'b1; aluOp = 2'b00; a = 32'd5; b = 32'd9;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_start done", 64'(done), 64'd0);
        check("reset_start result", 64'(result), 64'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
